// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - load-op encodings, NOP register address and op decode helper
package mem_wb_stage_pkg;

    localparam logic [4:0] NOP_REG = 5'd0;

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5
    } load_op_e;

    // Unused codes (6, 7) collapse to "no load" so WB falls back to the ALU result.
    function automatic load_op_e decode_load_op(input logic [2:0] code);
        case (code)
            3'd1:    decode_load_op = LOAD_LB;
            3'd2:    decode_load_op = LOAD_LBU;
            3'd3:    decode_load_op = LOAD_LH;
            3'd4:    decode_load_op = LOAD_LHU;
            3'd5:    decode_load_op = LOAD_LW;
            default: decode_load_op = LOAD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - little-endian byte/halfword lane select with sign/zero extension
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] data,
    input  load_op_e    load_op,
    input  logic [1:0]  addr_lo,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane; misaligned halfwords and words round down to their natural boundary.
    always_comb begin
        byte_lane = 8'd0;
        half_lane = addr_lo[1] ? data[31:16] : data[15:0];
        case (addr_lo)
            2'd0: byte_lane = data[7:0];
            2'd1: byte_lane = data[15:8];
            2'd2: byte_lane = data[23:16];
            2'd3: byte_lane = data[31:24];
            default: byte_lane = 8'd0;
        endcase

        load_data = data;
        case (load_op)
            LOAD_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
            LOAD_LBU: load_data = {24'd0, byte_lane};
            LOAD_LH:  load_data = {{16{half_lane[15]}}, half_lane};
            LOAD_LHU: load_data = {16'd0, half_lane};
            default:  load_data = data;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load alignment and stall-time read-data hold
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int LOAD_OP_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_mem,
    input  logic                 stall_wb,
    input  logic                 flush,
    input  logic [4:0]           mem_waddr,
    input  logic                 mem_we,
    input  logic [31:0]          mem_result,
    input  logic [LOAD_OP_W-1:0] mem_load_op,
    input  logic [1:0]           mem_addr_lo,
    input  logic [31:0]          dram_rdata,
    output logic [4:0]           wb_waddr,
    output logic [31:0]          wb_wdata,
    output logic                 wb_we
);

    logic [4:0]  waddr_r;
    logic        we_r;
    logic [31:0] result_r;
    load_op_e    load_op_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] hold_data;
    logic        hold_valid;

    load_op_e    mem_op_dec;
    logic [31:0] align_src;
    logic [31:0] aligned;

    // Anything wider than the defined codes, or above 5, is treated as no load.
    always_comb begin
        mem_op_dec = LOAD_NONE;
        if (mem_load_op <= LOAD_OP_W'(5)) begin
            mem_op_dec = decode_load_op(mem_load_op[2:0]);
        end
    end

    // WB registers plus the read-data hold that survives a WB stall (the RAM output moves on).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_r    <= 5'd0;
            we_r       <= 1'b0;
            result_r   <= 32'd0;
            load_op_r  <= LOAD_NONE;
            addr_lo_r  <= 2'd0;
            hold_data  <= 32'd0;
            hold_valid <= 1'b0;
        end else if (flush) begin
            waddr_r    <= 5'd0;
            we_r       <= 1'b0;
            result_r   <= 32'd0;
            load_op_r  <= LOAD_NONE;
            addr_lo_r  <= 2'd0;
            hold_valid <= 1'b0;
        end else if (stall_wb) begin
            if (load_op_r != LOAD_NONE && !hold_valid) begin
                hold_data  <= dram_rdata;
                hold_valid <= 1'b1;
            end
        end else if (stall_mem) begin
            waddr_r    <= 5'd0;
            we_r       <= 1'b0;
            result_r   <= 32'd0;
            load_op_r  <= LOAD_NONE;
            addr_lo_r  <= 2'd0;
            hold_valid <= 1'b0;
        end else begin
            waddr_r    <= mem_waddr;
            we_r       <= mem_we;
            result_r   <= mem_result;
            load_op_r  <= mem_op_dec;
            addr_lo_r  <= mem_addr_lo;
            hold_valid <= 1'b0;
        end
    end

    assign align_src = hold_valid ? hold_data : dram_rdata;

    mem_wb_stage_load_align u_load_align (
        .data      (align_src),
        .load_op   (load_op_r),
        .addr_lo   (addr_lo_r),
        .load_data (aligned)
    );

    // Regfile write port; $zero is never written and reset masks everything immediately.
    always_comb begin
        wb_waddr = waddr_r;
        wb_we    = we_r && (waddr_r != NOP_REG);
        wb_wdata = (load_op_r == LOAD_NONE) ? result_r : aligned;
        if (rst) begin
            wb_waddr = 5'd0;
            wb_we    = 1'b0;
            wb_wdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic [31:0] mem_result;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic [31:0] dram_rdata;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_we;

    int checks = 0;
    int failures = 0;

    mem_wb_stage #(.LOAD_OP_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_mem   (stall_mem),
        .stall_wb    (stall_wb),
        .flush       (flush),
        .mem_waddr   (mem_waddr),
        .mem_we      (mem_we),
        .mem_result  (mem_result),
        .mem_load_op (mem_load_op),
        .mem_addr_lo (mem_addr_lo),
        .dram_rdata  (dram_rdata),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .wb_we       (wb_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] wa, input logic we, input logic [31:0] res,
                             input logic [2:0] op, input logic [1:0] lo);
        mem_waddr   = wa;
        mem_we      = we;
        mem_result  = res;
        mem_load_op = op;
        mem_addr_lo = lo;
    endtask

    task automatic load_check(input string tag, input logic [2:0] op, input logic [1:0] lo,
                              input logic [31:0] exp);
        set_instr(5'd5, 1'b1, 32'hDEAD0000, op, lo);
        dram_rdata = 32'h0;
        step();
        dram_rdata = 32'h80FF7F01;
        #1;
        check(tag, wb_wdata, exp);
    endtask

    initial begin
        rst = 1'b1;
        stall_mem = 1'b0;
        stall_wb = 1'b0;
        flush = 1'b0;
        dram_rdata = 32'h0;
        set_instr(5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
        #2;
        check("reset_we", {31'd0, wb_we}, 32'd0);
        check("reset_waddr", {27'd0, wb_waddr}, 32'd0);
        check("reset_wdata", wb_wdata, 32'd0);
        step();
        step();
        #2;
        rst = 1'b0;

        // ALU write lands on the first edge after reset release
        set_instr(5'd3, 1'b1, 32'h12345678, 3'd0, 2'd0);
        step();
        check("alu_we", {31'd0, wb_we}, 32'd1);
        check("alu_waddr", {27'd0, wb_waddr}, 32'd3);
        check("alu_wdata", wb_wdata, 32'h12345678);

        // Load alignment against 0x80FF7F01
        load_check("lb_off3", 3'd1, 2'd3, 32'hFFFFFF80);
        load_check("lbu_off1", 3'd2, 2'd1, 32'h0000007F);
        load_check("lh_off2", 3'd3, 2'd2, 32'hFFFF80FF);
        load_check("lhu_off0", 3'd4, 2'd0, 32'h00007F01);
        load_check("lb_off0", 3'd1, 2'd0, 32'h00000001);
        load_check("lh_off3_unaligned", 3'd3, 2'd3, 32'hFFFF80FF);
        load_check("lw_off2_unaligned", 3'd5, 2'd2, 32'h80FF7F01);
        load_check("op6_is_alu", 3'd6, 2'd1, 32'hDEAD0000);
        load_check("op7_is_alu", 3'd7, 2'd0, 32'hDEAD0000);

        // Stall hold: LW in WB, RAM output changes underneath
        set_instr(5'd6, 1'b1, 32'h0, 3'd5, 2'd0);
        step();
        dram_rdata = 32'hCAFEBABE;
        stall_wb = 1'b1;
        set_instr(5'd7, 1'b1, 32'h11111111, 3'd0, 2'd0);
        #1;
        check("stall_live", wb_wdata, 32'hCAFEBABE);
        for (int i = 0; i < 3; i++) begin
            step();
            dram_rdata = 32'h0;
            #1;
            check($sformatf("stall_hold_%0d", i), wb_wdata, 32'hCAFEBABE);
            check($sformatf("stall_waddr_%0d", i), {27'd0, wb_waddr}, 32'd6);
        end
        stall_wb = 1'b0;
        step();
        check("after_stall_wdata", wb_wdata, 32'h11111111);
        check("after_stall_waddr", {27'd0, wb_waddr}, 32'd7);

        // Bubble on MEM stall
        stall_mem = 1'b1;
        step();
        check("bubble_we", {31'd0, wb_we}, 32'd0);
        check("bubble_waddr", {27'd0, wb_waddr}, 32'd0);
        stall_mem = 1'b0;

        // Flush together with WB stall while a held load sits in WB
        set_instr(5'd9, 1'b1, 32'h0, 3'd5, 2'd0);
        step();
        stall_wb = 1'b1;
        dram_rdata = 32'h11112222;
        step();
        dram_rdata = 32'h33334444;
        #1;
        check("pre_flush_hold", wb_wdata, 32'h11112222);
        flush = 1'b1;
        step();
        check("flush_we", {31'd0, wb_we}, 32'd0);
        check("flush_wdata", wb_wdata, 32'd0);
        check("flush_hold_clear", {31'd0, dut.hold_valid}, 32'd0);
        flush = 1'b0;
        stall_wb = 1'b0;

        // Write to $zero is suppressed
        set_instr(5'd0, 1'b1, 32'hFFFFFFFF, 3'd0, 2'd0);
        step();
        check("zero_we", {31'd0, wb_we}, 32'd0);

        // Reset pulsed between edges with a load in WB
        set_instr(5'd12, 1'b1, 32'h0, 3'd5, 2'd0);
        dram_rdata = 32'hAAAA5555;
        step();
        check("preload_we", {31'd0, wb_we}, 32'd1);
        check("preload_wdata", wb_wdata, 32'hAAAA5555);
        set_instr(5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_we", {31'd0, wb_we}, 32'd0);
        check("rst_mid_waddr", {27'd0, wb_waddr}, 32'd0);
        check("rst_mid_wdata", wb_wdata, 32'd0);
        #2;
        rst = 1'b0;
        step();
        check("post_rst_we", {31'd0, wb_we}, 32'd0);
        check("post_rst_wdata", wb_wdata, 32'd0);
        set_instr(5'd4, 1'b1, 32'h0BADF00D, 3'd0, 2'd0);
        step();
        check("post_rst_capture_we", {31'd0, wb_we}, 32'd1);
        check("post_rst_capture_wdata", wb_wdata, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
